// File: rtl/usb_rx.sv
// usb_rx: full-speed USB receive front end.
//
// The raw D+/D- pair is sampled at 48 MHz (4x the bit rate). Bit timing is
// recovered from J<->K transitions. The front end then NRZI-decodes the bits,
// removes stuff bits, detects SYNC, assembles bytes and detects EOP. Bytes
// are delivered one byte late, so the final byte of a packet can be flagged
// as last when the EOP arrives. A long SE0 on the bus is reported as a bus
// reset.
//
// Ports:
//   clk48          in   48 MHz clock; the only clock
//   resetN         in   asynchronous active-low reset
//   dataInP/N      in   raw D+/D- from the pad, asynchronous to clk48
//   isSending      in   local transmitter owns the bus; receiver held idle
//   rxData         out  received byte, valid only while rxDataValid=1
//   rxDataValid    out  one-cycle strobe per delivered byte
//   rxIsLastByte   out  qualifies rxDataValid: final byte before EOP
//   rxError        out  one-cycle strobe: stuff error or unaligned EOP
//   receiving      out  high from SYNC acceptance until EOP/abort
//   usbResetDetect out  high while SE0 has lasted >= RESET_SE0_CYCLES
module usb_rx #(
    parameter int RESET_SE0_CYCLES = 120,
    parameter int SYNC_MIN_ZEROS   = 5,
    parameter int SAMPLE_PHASE     = 2
) (
    input  logic       clk48,
    input  logic       resetN,
    input  logic       dataInP,
    input  logic       dataInN,
    input  logic       isSending,
    output logic [7:0] rxData,
    output logic       rxDataValid,
    output logic       rxIsLastByte,
    output logic       rxError,
    output logic       receiving,
    output logic       usbResetDetect
);
    localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);
    localparam int CW = $clog2(RESET_SE0_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP_WAIT} state_t;

    // Two-flop synchronizers; reset to the idle J level so no false SE0 is seen.
    logic p_p1, p_p2, n_p1, n_p2;
    logic p_last, n_last;

    always_ff @(posedge clk48 or negedge resetN) begin
        if (!resetN) begin
            p_p1   <= 1'b1;
            p_p2   <= 1'b1;
            n_p1   <= 1'b0;
            n_p2   <= 1'b0;
            p_last <= 1'b1;
            n_last <= 1'b0;
        end else begin
            p_p1   <= dataInP;
            p_p2   <= p_p1;
            n_p1   <= dataInN;
            n_p2   <= n_p1;
            p_last <= p_p2;
            n_last <= n_p2;
        end
    end

    logic line_j, line_k, line_se0, bus_se0, diff_edge;
    assign line_j    = p_p2 & ~n_p2;
    assign line_k    = ~p_p2 & n_p2;
    assign line_se0  = ~(line_j | line_k);   // SE1 is lumped with SE0
    assign bus_se0   = ~p_p2 & ~n_p2;
    // Only a genuine J<->K change re-aligns the bit clock; SE0 edges do not.
    assign diff_edge = (line_j & ~p_last & n_last) | (line_k & p_last & ~n_last);

    // The edge cycle itself counts as phase 0, so the sample lands mid-bit.
    logic [1:0] phase, phase_eff;
    logic       sample;
    assign phase_eff = diff_edge ? 2'd0 : phase;
    assign sample    = (phase_eff == 2'(SAMPLE_PHASE));

    state_t        state, state_n;
    logic [ZW-1:0] zero_cnt, zero_cnt_n;
    logic [2:0]    stuff_cnt, stuff_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic          held_vld, held_vld_n;
    logic          prev_level, prev_level_n;
    logic [6:0]    shreg, shreg_n;           // previous 7 bits; 8th completes a byte
    logic [7:0]    held, held_n;
    logic [7:0]    data_n;
    logic          valid_n, last_n, err_n;
    logic          bit_dec;

    assign bit_dec   = (p_p2 == prev_level);  // NRZI: no change means 1
    assign receiving = (state == DATA);

    always_comb begin
        state_n      = state;
        zero_cnt_n   = zero_cnt;
        stuff_cnt_n  = stuff_cnt;
        bit_cnt_n    = bit_cnt;
        held_vld_n   = held_vld;
        prev_level_n = prev_level;
        shreg_n      = shreg;
        held_n       = held;
        data_n       = rxData;
        valid_n      = 1'b0;
        last_n       = 1'b0;
        err_n        = 1'b0;

        if (isSending) begin
            state_n      = IDLE;
            stuff_cnt_n  = 3'd0;
            prev_level_n = 1'b1;
            held_vld_n   = 1'b0;
        end else if (sample) begin
            prev_level_n = p_p2;
            case (state)
                IDLE: begin
                    zero_cnt_n  = '0;
                    stuff_cnt_n = 3'd0;
                    if (line_k) state_n = SYNC;
                end
                SYNC: begin
                    if (line_se0) begin
                        state_n = IDLE;
                    end else if (bit_dec) begin
                        if (int'(zero_cnt) >= SYNC_MIN_ZEROS) begin
                            // The closing 1 of SYNC already counts toward stuffing.
                            state_n     = DATA;
                            stuff_cnt_n = 3'd1;
                            bit_cnt_n   = 3'd0;
                            held_vld_n  = 1'b0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (int'(zero_cnt) < SYNC_MIN_ZEROS) begin
                        zero_cnt_n = zero_cnt + ZW'(1);
                    end
                end
                DATA: begin
                    if (line_se0) begin
                        state_n    = EOP_WAIT;
                        held_vld_n = 1'b0;
                        if (held_vld) begin
                            valid_n = 1'b1;
                            last_n  = 1'b1;
                            data_n  = held;
                        end
                        if (bit_cnt != 3'd0 || !held_vld) err_n = 1'b1;
                    end else if (stuff_cnt == 3'd6) begin
                        // Stuff bit: must be a 0 and is never shifted in.
                        stuff_cnt_n = 3'd0;
                        if (bit_dec) begin
                            err_n      = 1'b1;
                            held_vld_n = 1'b0;
                            state_n    = EOP_WAIT;
                        end
                    end else begin
                        stuff_cnt_n = bit_dec ? stuff_cnt + 3'd1 : 3'd0;
                        shreg_n     = {bit_dec, shreg[6:1]};
                        bit_cnt_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (held_vld) begin
                                valid_n = 1'b1;
                                data_n  = held;
                            end
                            held_n     = {bit_dec, shreg};
                            held_vld_n = 1'b1;
                        end
                    end
                end
                EOP_WAIT: begin
                    if (line_j) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk48 or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            phase        <= 2'd0;
            zero_cnt     <= '0;
            stuff_cnt    <= 3'd0;
            bit_cnt      <= 3'd0;
            held_vld     <= 1'b0;
            prev_level   <= 1'b1;
            rxData       <= 8'd0;
            rxDataValid  <= 1'b0;
            rxIsLastByte <= 1'b0;
            rxError      <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= phase_eff + 2'd1;
            zero_cnt     <= zero_cnt_n;
            stuff_cnt    <= stuff_cnt_n;
            bit_cnt      <= bit_cnt_n;
            held_vld     <= held_vld_n;
            prev_level   <= prev_level_n;
            rxData       <= data_n;
            rxDataValid  <= valid_n;
            rxIsLastByte <= last_n;
            rxError      <= err_n;
        end
    end

    // Byte assembly storage; qualified by bit_cnt/held_vld so no reset needed.
    always_ff @(posedge clk48) begin
        shreg <= shreg_n;
        held  <= held_n;
    end

    // Bus reset: saturating count of synced SE0 cycles, independent of the FSM.
    logic [CW-1:0] se0_cnt;

    always_ff @(posedge clk48 or negedge resetN) begin
        if (!resetN) begin
            se0_cnt        <= '0;
            usbResetDetect <= 1'b0;
        end else if (bus_se0) begin
            if (se0_cnt != CW'(RESET_SE0_CYCLES)) se0_cnt <= se0_cnt + CW'(1);
            if (int'(se0_cnt) >= RESET_SE0_CYCLES - 1) usbResetDetect <= 1'b1;
        end else begin
            se0_cnt        <= '0;
            usbResetDetect <= 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_rx.sv
// tb_usb_rx: self-checking bench for usb_rx.
//
// Packets are described as byte lists, encoded on the fly (SYNC, bit
// stuffing, NRZI, EOP) and driven onto the D+/D- pins with either a fixed
// 4-cycle bit period or periods alternating 3/5 cycles. Every strobe seen on
// the outputs is logged and compared with the list the encoder expects.
module tb_usb_rx;
    logic       clk48 = 1'b0;
    logic       resetN;
    logic       dataInP;
    logic       dataInN;
    logic       isSending;
    logic [7:0] rxData;
    logic       rxDataValid;
    logic       rxIsLastByte;
    logic       rxError;
    logic       receiving;
    logic       usbResetDetect;

    always #5 clk48 = ~clk48;

    usb_rx dut (
        .clk48          (clk48),
        .resetN         (resetN),
        .dataInP        (dataInP),
        .dataInN        (dataInN),
        .isSending      (isSending),
        .rxData         (rxData),
        .rxDataValid    (rxDataValid),
        .rxIsLastByte   (rxIsLastByte),
        .rxError        (rxError),
        .receiving      (receiving),
        .usbResetDetect (usbResetDetect)
    );

    int          checks = 0;
    int          errors = 0;
    logic [10:0] ev_q[$];    // {valid, error, last, data}
    logic [10:0] exp_q[$];
    bit          dbits[$];   // packet payload bits, LSB-first
    bit          rcv_seen;

    // Encoder state
    logic cur_lvl;
    bit   alt;
    int   ones;
    int   emitted;
    int   max_emit;
    int   per_mode;

    always @(negedge clk48) begin
        if (rxDataValid || rxError) ev_q.push_back({rxDataValid, rxError, rxIsLastByte, rxData});
        if (receiving) rcv_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmp_events(input string tag);
        logic [10:0] m;
        chk({tag, "_count"}, ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            // Data and last flag are only meaningful alongside a valid strobe.
            m = exp_q[i][10] ? 11'h7FF : 11'h600;
            chk($sformatf("%s_ev%0d", tag, i), ev_q[i] & m, exp_q[i] & m);
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    task automatic drive(input logic p, input logic n, input int cyc);
        dataInP = p;
        dataInN = n;
        repeat (cyc) @(negedge clk48);
    endtask

    task automatic emit(input logic lvl);
        int per;
        if (per_mode == 0) per = 4;
        else begin
            per = alt ? 5 : 3;
            alt = ~alt;
        end
        if (max_emit == 0 || emitted < max_emit) begin
            drive(lvl, ~lvl, per);
            emitted++;
        end
    endtask

    task automatic enc_bit(input bit b, input bit stuff_en);
        if (!b) cur_lvl = ~cur_lvl;
        emit(cur_lvl);
        ones = b ? ones + 1 : 0;
        if (stuff_en && ones == 6) begin
            cur_lvl = ~cur_lvl;
            emit(cur_lvl);
            ones = 0;
        end
    endtask

    // SYNC + dbits, then SE0 for two bit times and J idle (unless truncated).
    task automatic send(input bit stuff_en, input int mode, input int limit);
        per_mode = mode;
        max_emit = limit;
        emitted  = 0;
        alt      = 1'b0;
        cur_lvl  = 1'b1;
        ones     = 0;
        for (int i = 0; i < 8; i++) enc_bit(i == 7, stuff_en);
        for (int i = 0; i < dbits.size(); i++) enc_bit(dbits[i], stuff_en);
        dbits.delete();
        if (limit == 0) begin
            drive(1'b0, 1'b0, 8);
            drive(1'b1, 1'b0, 12);
        end
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) dbits.push_back(b[i]);
    endtask

    task automatic expect_byte(input logic [7:0] b, input bit last);
        exp_q.push_back({1'b1, 1'b0, last, b});
    endtask

    initial begin
        int          n;
        int          mode;
        logic [7:0]  b;

        resetN    = 1'b0;
        dataInP   = 1'b1;
        dataInN   = 1'b0;
        isSending = 1'b0;
        repeat (3) @(negedge clk48);
        chk("rst_valid", rxDataValid, 0);
        chk("rst_error", rxError, 0);
        chk("rst_last", rxIsLastByte, 0);
        chk("rst_data", rxData, 0);
        chk("rst_receiving", receiving, 0);
        chk("rst_busreset", usbResetDetect, 0);
        resetN = 1'b1;
        drive(1'b1, 1'b0, 10);

        // Two-byte packet at nominal rate.
        ev_q.delete();
        rcv_seen = 1'b0;
        add_byte(8'hC3); add_byte(8'h01);
        expect_byte(8'hC3, 1'b0); expect_byte(8'h01, 1'b1);
        send(1'b1, 0, 0);
        cmp_events("c3_01");
        chk("c3_rcv_seen", rcv_seen, 1);
        chk("c3_rcv_end", receiving, 0);

        // Long runs of ones force stuff bits.
        add_byte(8'hFF); add_byte(8'h3F);
        expect_byte(8'hFF, 1'b0); expect_byte(8'h3F, 1'b1);
        send(1'b1, 0, 0);
        cmp_events("ff_3f");

        // Missing stuff bit: error pulse only, then a clean packet decodes.
        rcv_seen = 1'b0;
        add_byte(8'hFF);
        exp_q.push_back(11'h200);
        send(1'b0, 0, 0);
        cmp_events("stuff_err");
        chk("stuff_rcv_end", receiving, 0);
        b = 8'($urandom);
        add_byte(b); expect_byte(b, 1'b1);
        send(1'b1, 0, 0);
        cmp_events("after_stuff_err");

        // EOP not on a byte boundary.
        add_byte(8'hA5);
        n = $urandom_range(1, 7);
        for (int i = 0; i < n; i++) dbits.push_back(1'($urandom));
        exp_q.push_back({1'b1, 1'b1, 1'b1, 8'hA5});
        send(1'b1, 0, 0);
        cmp_events("a5_partial");

        // Bus reset: 130 cycles of SE0.
        dataInP = 1'b0;
        dataInN = 1'b0;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk48);
            if (k == 121) chk("busrst_before", usbResetDetect, 0);
            if (k == 122) chk("busrst_rise", usbResetDetect, 1);
            if (k == 130) chk("busrst_hold", usbResetDetect, 1);
        end
        dataInP = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk48);
            if (k == 2) chk("busrst_still", usbResetDetect, 1);
            if (k == 3) chk("busrst_fall", usbResetDetect, 0);
        end
        drive(1'b1, 1'b0, 12);
        cmp_events("busrst_nodata");

        // Jittered bit periods.
        add_byte(8'h5A); expect_byte(8'h5A, 1'b1);
        send(1'b1, 1, 0);
        cmp_events("jitter_5a");

        // Random packets at random rate.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 4);
            mode = $urandom_range(0, 1);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                add_byte(b);
                expect_byte(b, i == n - 1);
            end
            send(1'b1, mode, 0);
            cmp_events($sformatf("rand%0d", r));
        end

        // Transmitter owns the bus: nothing is received.
        isSending = 1'b1;
        rcv_seen  = 1'b0;
        add_byte(8'($urandom));
        send(1'b1, 0, 0);
        isSending = 1'b0;
        drive(1'b1, 1'b0, 8);
        cmp_events("sending");
        chk("sending_rcv", rcv_seen, 0);

        // Reset in the middle of a byte.
        add_byte(8'h5A);
        send(1'b1, 1, 12);
        chk("abort_rcv_before", receiving, 1);
        resetN = 1'b0;
        #1;
        chk("abort_valid", rxDataValid, 0);
        chk("abort_error", rxError, 0);
        chk("abort_last", rxIsLastByte, 0);
        chk("abort_data", rxData, 0);
        chk("abort_receiving", receiving, 0);
        chk("abort_busreset", usbResetDetect, 0);
        dataInP = 1'b1;
        dataInN = 1'b0;
        repeat (3) @(negedge clk48);
        resetN = 1'b1;
        drive(1'b1, 1'b0, 10);
        cmp_events("abort");
        b = 8'($urandom);
        add_byte(8'h5A); add_byte(b);
        expect_byte(8'h5A, 1'b0); expect_byte(b, 1'b1);
        send(1'b1, 1, 0);
        cmp_events("post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
